// File: rtl/exec_stage_mc.sv
// exec_stage_mc -- execute stage of the pipelined ARM core.
//
// Holds the ID/EX register, selects operands through an N-way forwarding mux,
// barrel-shifts register operand B, runs the ALU, keeps the NZCV flag register,
// evaluates the ARM condition field and drives the EX/MEM register. MUL is
// executed by an iterative shift-add unit over MUL_CYCLES E cycles; while it is
// busy stall_o asks the hazard unit to hold F/D, and M receives bubbles.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   stall_i / flush_i          hold / bubble the E register (hazard unit)
//   ctrl_d                     {pcsrc,regwrite,memtoreg,memwrite,branch,alusrc}
//   alucontrol_d               000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 MUL
//   flagwrite_d                [1] update N,Z   [0] update C,V
//   cond_d                     ARM condition field
//   sh_d, shamt_d              shift type (LSL/LSR/ASR/ROR) and amount for operand B
//   writeaddr_d                destination register
//   rd1_d, rd2_d, ext_d        register operands and extended immediate
//   fwd_a_e, fwd_b_e           0 = register value, k = fwd_data slice k-1
//   fwd_data                   packed forwarding values, slice k at [k*WIDTH +: WIDTH]
//   stall_o                    MUL busy
//   ctrl_m                     {pcsrc,regwrite,memtoreg,memwrite,branch}, condition gated
//   aluresult_m, writedata_m,
//   writeaddr_m                EX/MEM register contents
//   aluresult_e                combinational E result
//   flags_o                    NZCV register
module exec_stage_mc #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_FWD    = 2,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall_i,
  input  logic                               flush_i,
  input  logic [5:0]                         ctrl_d,
  input  logic [2:0]                         alucontrol_d,
  input  logic [1:0]                         flagwrite_d,
  input  logic [3:0]                         cond_d,
  input  logic [1:0]                         sh_d,
  input  logic [$clog2(WIDTH)-1:0]           shamt_d,
  input  logic [3:0]                         writeaddr_d,
  input  logic [WIDTH-1:0]                   rd1_d,
  input  logic [WIDTH-1:0]                   rd2_d,
  input  logic [WIDTH-1:0]                   ext_d,
  input  logic [$clog2(NUM_FWD+1)-1:0]       fwd_a_e,
  input  logic [$clog2(NUM_FWD+1)-1:0]       fwd_b_e,
  input  logic [NUM_FWD*WIDTH-1:0]           fwd_data,
  output logic                               stall_o,
  output logic [4:0]                         ctrl_m,
  output logic [WIDTH-1:0]                   aluresult_m,
  output logic [WIDTH-1:0]                   writedata_m,
  output logic [3:0]                         writeaddr_m,
  output logic [WIDTH-1:0]                   aluresult_e,
  output logic [3:0]                         flags_o
);

  localparam int unsigned SW    = $clog2(WIDTH);
  localparam int unsigned FW    = $clog2(NUM_FWD + 1);
  localparam int unsigned CHUNK = WIDTH / MUL_CYCLES;
  localparam int unsigned CW    = $clog2(MUL_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MUL = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } mul_state_e;

  // ---------------------------------------------------------------- E register
  logic [5:0]       ctrl_e;
  logic [2:0]       alucontrol_e;
  logic [1:0]       flagwrite_e;
  logic [3:0]       cond_e;
  logic [1:0]       sh_e;
  logic [SW-1:0]    shamt_e;
  logic [3:0]       writeaddr_e;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic [WIDTH-1:0] ext_e;

  mul_state_e state, state_n;
  logic       retire_hold;

  // A MUL retiring while stall_i holds E must not be seen again as a fresh MUL,
  // so its E slot is turned into a bubble at the retiring edge.
  assign retire_hold = (state == S_DONE) && stall_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e       <= '0;
      alucontrol_e <= '0;
      flagwrite_e  <= '0;
      cond_e       <= '0;
      sh_e         <= '0;
      shamt_e      <= '0;
      writeaddr_e  <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      ext_e        <= '0;
    end else if (flush_i || retire_hold) begin
      ctrl_e       <= '0;
      alucontrol_e <= '0;
      flagwrite_e  <= '0;
    end else if (!(stall_i || stall_o)) begin
      ctrl_e       <= ctrl_d;
      alucontrol_e <= alucontrol_d;
      flagwrite_e  <= flagwrite_d;
      cond_e       <= cond_d;
      sh_e         <= sh_d;
      shamt_e      <= shamt_d;
      writeaddr_e  <= writeaddr_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      ext_e        <= ext_d;
    end
  end

  // ---------------------------------------------------------------- operands
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b_raw;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] src_b;
  logic [SW:0]      rot_inv;

  always_comb begin
    src_a     = rd1_e;
    src_b_raw = rd2_e;
    for (int unsigned k = 1; k <= NUM_FWD; k++) begin
      if (fwd_a_e == FW'(k)) src_a     = fwd_data[(k-1)*WIDTH +: WIDTH];
      if (fwd_b_e == FW'(k)) src_b_raw = fwd_data[(k-1)*WIDTH +: WIDTH];
    end
  end

  // ROR with shamt 0 shifts left by WIDTH, which yields 0, leaving pass-through.
  assign rot_inv = (SW+1)'(WIDTH) - {1'b0, shamt_e};

  always_comb begin
    case (sh_e)
      2'b00:   shifted = src_b_raw << shamt_e;
      2'b01:   shifted = src_b_raw >> shamt_e;
      2'b10:   shifted = WIDTH'($signed(src_b_raw) >>> shamt_e);
      default: shifted = (src_b_raw >> shamt_e) | (src_b_raw << rot_inv);
    endcase
  end

  assign src_b = ctrl_e[0] ? ext_e : shifted;

  // ---------------------------------------------------------------- MUL unit
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] first_pp;
  logic [WIDTH-1:0] step_pp;
  logic [WIDTH-1:0] mul_final;
  logic             is_mul;
  logic             mul_bubble;

  function automatic logic [WIDTH-1:0] chunk_mul(input logic [WIDTH-1:0] md,
                                                 input logic [CHUNK-1:0] bits);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (bits[i]) p = p + (md << i);
    end
    return p;
  endfunction

  assign is_mul    = (alucontrol_e == OP_MUL);
  // The first chunk is consumed in the IDLE cycle straight from the operand
  // muxes, so the whole product fits into exactly MUL_CYCLES E cycles.
  assign first_pp  = chunk_mul(src_a, src_b[CHUNK-1:0]);
  assign step_pp   = chunk_mul(mcand, mplier[CHUNK-1:0]);
  assign mul_final = acc + step_pp;
  // MUL in E but not yet in its final cycle: M must take a bubble.
  assign mul_bubble = is_mul && (state != S_DONE);
  assign stall_o   = (state == S_RUN) || ((state == S_IDLE) && is_mul);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    case (state)
      S_IDLE: begin
        if (is_mul && !flush_i) begin
          acc_n    = first_pp;
          mcand_n  = src_a << CHUNK;
          mplier_n = src_b >> CHUNK;
          cnt_n    = CW'(MUL_CYCLES - 1);
          state_n  = (MUL_CYCLES == 2) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_n = S_IDLE;
        end else begin
          acc_n    = mul_final;
          mcand_n  = mcand << CHUNK;
          mplier_n = mplier >> CHUNK;
          cnt_n    = cnt - CW'(1);
          if (cnt == CW'(2)) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             nz_op;
  logic             cv_op;

  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    nz_op   = 1'b0;
    cv_op   = 1'b0;
    case (alucontrol_e)
      OP_ADD: begin
        sum_ext = {1'b0, src_a} + {1'b0, src_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
        nz_op   = 1'b1;
        cv_op   = 1'b1;
      end
      OP_SUB: begin
        sum_ext = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
        nz_op   = 1'b1;
        cv_op   = 1'b1;
      end
      OP_AND: begin
        alu_res = src_a & src_b;
        nz_op   = 1'b1;
      end
      OP_ORR: begin
        alu_res = src_a | src_b;
        nz_op   = 1'b1;
      end
      OP_EOR: begin
        alu_res = src_a ^ src_b;
        nz_op   = 1'b1;
      end
      OP_MUL: begin
        alu_res = (state == S_DONE) ? mul_final : '0;
        nz_op   = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluresult_e = alu_res;

  // ---------------------------------------------------------------- condition
  logic cond_ex;
  logic fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_o;

  always_comb begin
    case (cond_e)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = !fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = !fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = !fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = !fv;
      4'b1000: cond_ex = fc && !fz;
      4'b1001: cond_ex = !fc || fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = !fz && (fn == fv);
      4'b1101: cond_ex = fz || (fn != fv);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- flags
  logic nz_we;
  logic cv_we;

  assign nz_we = cond_ex && flagwrite_e[1] && nz_op && !mul_bubble;
  assign cv_we = cond_ex && flagwrite_e[0] && cv_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_o <= '0;
    end else begin
      if (nz_we) flags_o[3:2] <= {alu_res[WIDTH-1], alu_res == '0};
      if (cv_we) flags_o[1:0] <= {alu_c, alu_v};
    end
  end

  // ---------------------------------------------------------------- M register
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_m      <= '0;
      aluresult_m <= '0;
      writedata_m <= '0;
      writeaddr_m <= '0;
    end else begin
      ctrl_m      <= (cond_ex && !mul_bubble) ? ctrl_e[5:1] : '0;
      aluresult_m <= alu_res;
      writedata_m <= src_b_raw;
      writeaddr_m <= writeaddr_e;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc -- randomized bench for exec_stage_mc against a
// transaction-level reference model (plain 64-bit arithmetic per instruction).
module tb_exec_stage_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic [5:0]  ctrl_d;
  logic [2:0]  alucontrol_d;
  logic [1:0]  flagwrite_d;
  logic [3:0]  cond_d;
  logic [1:0]  sh_d;
  logic [4:0]  shamt_d;
  logic [3:0]  writeaddr_d;
  logic [31:0] rd1_d, rd2_d, ext_d;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [63:0] fwd_data;
  logic        stall_o;
  logic [4:0]  ctrl_m;
  logic [31:0] aluresult_m, writedata_m, aluresult_e;
  logic [3:0]  writeaddr_m;
  logic [3:0]  flags_o;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] mflags;

  exec_stage_mc #(.WIDTH(32), .NUM_FWD(2), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .ctrl_d(ctrl_d), .alucontrol_d(alucontrol_d), .flagwrite_d(flagwrite_d),
    .cond_d(cond_d), .sh_d(sh_d), .shamt_d(shamt_d), .writeaddr_d(writeaddr_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ext_d(ext_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_data(fwd_data),
    .stall_o(stall_o), .ctrl_m(ctrl_m), .aluresult_m(aluresult_m),
    .writedata_m(writedata_m), .writeaddr_m(writeaddr_m),
    .aluresult_e(aluresult_e), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic [2:0]  op;
    logic [1:0]  fw;
    logic [3:0]  cond;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic [3:0]  wa;
    logic [31:0] rd1, rd2, ext, fd0, fd1;
    logic [1:0]  fa, fb;
  } instr_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] f0, input logic [31:0] f1);
    if (sel == 2'd1) return f0;
    if (sel == 2'd2) return f1;
    return r;
  endfunction

  function automatic logic [31:0] mshift(input logic [31:0] x, input logic [1:0] sh,
                                         input int s);
    longint sx;
    logic [31:0] y;
    case (sh)
      2'd0: return x << s;
      2'd1: return x >> s;
      2'd2: begin sx = $signed(x); sx = sx >>> s; return sx[31:0]; end
      default: begin
        y = x;
        for (int i = 0; i < s; i++) y = {y[0], y[31:1]};
        return y;
      end
    endcase
  endfunction

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input instr_t in, input logic [3:0] fl, output logic [31:0] res,
                       output logic [4:0] cm, output logic [3:0] fl_n, output logic [31:0] wd);
    logic [31:0] a, b;
    longint unsigned ua, ub, us;
    longint sa, sb, sr;
    logic c, v, ok, nz_ok, cv_ok;
    a  = pick(in.fa, in.rd1, in.fd0, in.fd1);
    wd = pick(in.fb, in.rd2, in.fd0, in.fd1);
    b  = in.ctrl[0] ? in.ext : mshift(wd, in.sh, int'(in.shamt));
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; nz_ok = 1'b1; cv_ok = 1'b0; res = 32'd0;
    case (in.op)
      3'd0: begin
        us = ua + ub; res = us[31:0]; c = us[32];
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); cv_ok = 1'b1;
      end
      3'd1: begin
        res = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); cv_ok = 1'b1;
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin us = ua * ub; res = us[31:0]; end
      default: begin res = 32'd0; nz_ok = 1'b0; end
    endcase
    ok   = cond_pass(in.cond, fl);
    cm   = ok ? in.ctrl[5:1] : 5'd0;
    fl_n = fl;
    if (ok && in.fw[1] && nz_ok) fl_n[3:2] = {res[31], res == 32'd0};
    if (ok && in.fw[0] && cv_ok) fl_n[1:0] = {c, v};
  endtask

  // ------------------------------------------------------------ stimulus helpers
  function automatic instr_t base_instr();
    instr_t t;
    t.ctrl = 6'b010000; t.op = 3'd0; t.fw = 2'b00; t.cond = 4'he;
    t.sh = 2'd0; t.shamt = 5'd0; t.wa = 4'd3;
    t.rd1 = 32'd0; t.rd2 = 32'd0; t.ext = 32'd0; t.fd0 = 32'd0; t.fd1 = 32'd0;
    t.fa = 2'd0; t.fb = 2'd0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.ctrl = 6'($urandom); t.op = 3'($urandom); t.fw = 2'($urandom);
    t.cond = ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom);
    t.sh = 2'($urandom); t.shamt = 5'($urandom); t.wa = 4'($urandom);
    t.rd1 = $urandom; t.rd2 = $urandom; t.ext = $urandom;
    t.fd0 = $urandom; t.fd1 = $urandom;
    if ($urandom_range(0, 3) == 0) t.rd2 = t.rd1;
    t.fa = 2'($urandom_range(0, 2)); t.fb = 2'($urandom_range(0, 2));
    return t;
  endfunction

  task automatic drive_d(input instr_t in);
    ctrl_d = in.ctrl; alucontrol_d = in.op; flagwrite_d = in.fw; cond_d = in.cond;
    sh_d = in.sh; shamt_d = in.shamt; writeaddr_d = in.wa;
    rd1_d = in.rd1; rd2_d = in.rd2; ext_d = in.ext;
  endtask

  task automatic bubble_d();
    ctrl_d = '0; alucontrol_d = '0; flagwrite_d = '0; cond_d = 4'($urandom);
    sh_d = 2'($urandom); shamt_d = 5'($urandom); writeaddr_d = 4'($urandom);
    rd1_d = $urandom; rd2_d = $urandom; ext_d = $urandom;
  endtask

  // Issue one instruction, let it pass E, check M and flags after it leaves E.
  task automatic run_instr(input instr_t in);
    logic [31:0] eres, ewd;
    logic [4:0]  ecm;
    logic [3:0]  efl;
    drive_d(in);
    @(posedge clk); #1;
    bubble_d();
    fwd_a_e = in.fa; fwd_b_e = in.fb; fwd_data = {in.fd1, in.fd0};
    model(in, mflags, eres, ecm, efl, ewd);
    if (in.op == 3'd5) begin
      for (int k = 0; k < 3; k++) begin
        #1; check("mul_stall_hi", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        check("mul_bubble_ctrl", 32'(ctrl_m), 32'd0);
        fwd_data = {$urandom, $urandom};
      end
      #1; check("mul_stall_lo", 32'(stall_o), 32'd0);
    end else begin
      #1; check("stall_idle", 32'(stall_o), 32'd0);
    end
    @(posedge clk); #1;
    check("aluresult_m", aluresult_m, eres);
    check("ctrl_m", 32'(ctrl_m), 32'(ecm));
    check("writeaddr_m", 32'(writeaddr_m), 32'(in.wa));
    if (in.op != 3'd5) check("writedata_m", writedata_m, ewd);
    check("flags_o", 32'(flags_o), 32'(efl));
    mflags = efl;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    instr_t t;
    logic [31:0] eres, ewd;
    logic [4:0]  ecm;
    logic [3:0]  efl;

    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    fwd_a_e = '0; fwd_b_e = '0; fwd_data = '0;
    bubble_d();
    mflags = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_ctrl_m", 32'(ctrl_m), 32'd0);
    check("rst_aluresult_m", aluresult_m, 32'd0);
    check("rst_writedata_m", writedata_m, 32'd0);
    check("rst_writeaddr_m", 32'(writeaddr_m), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);

    // ADD 7 + (-7)
    t = base_instr(); t.rd1 = 32'd7; t.rd2 = 32'hFFFF_FFF9; t.fw = 2'b11;
    run_instr(t);
    check("add_zero_res", aluresult_m, 32'd0);
    check("add_zero_flags", 32'(flags_o), 32'b0110);

    // SUB 5 - 9 with A forwarded from slice 0
    t = base_instr(); t.op = 3'd1; t.fa = 2'd1; t.fd0 = 32'd5; t.rd1 = 32'd77;
    t.rd2 = 32'd9; t.fw = 2'b11;
    run_instr(t);
    check("sub_res", aluresult_m, 32'hFFFF_FFFC);
    check("sub_flags", 32'(flags_o), 32'b1000);

    // EQ with Z=0: suppressed
    t = base_instr(); t.cond = 4'd0; t.rd1 = 32'd1; t.rd2 = 32'd1; t.fw = 2'b11;
    run_instr(t);
    check("eq_ctrl_gated", 32'(ctrl_m), 32'd0);
    check("eq_flags_kept", 32'(flags_o), 32'b1000);

    // MUL 0x12345678 * 3
    t = base_instr(); t.op = 3'd5; t.rd1 = 32'h1234_5678; t.rd2 = 32'd3; t.fw = 2'b10;
    run_instr(t);
    check("mul_res", aluresult_m, 32'h369D_0368);

    // LSL 1 by 31, ORR with 0
    t = base_instr(); t.op = 3'd3; t.rd2 = 32'd1; t.shamt = 5'd31; t.fw = 2'b10;
    run_instr(t);
    check("lsl_res", aluresult_m, 32'h8000_0000);
    check("lsl_n", 32'(flags_o[3]), 32'd1);

    // ROR 0xF by 4
    t = base_instr(); t.op = 3'd3; t.rd2 = 32'hF; t.sh = 2'd3; t.shamt = 5'd4; t.fw = 2'b10;
    run_instr(t);
    check("ror_res", aluresult_m, 32'hF000_0000);

    // flush in the second MUL cycle
    t = base_instr(); t.op = 3'd5; t.rd1 = 32'd1000; t.rd2 = 32'd1000; t.fw = 2'b10;
    drive_d(t);
    @(posedge clk); #1;
    bubble_d(); fwd_a_e = '0; fwd_b_e = '0;
    @(posedge clk); #1;
    check("flush_pre_stall", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_stall_lo", 32'(stall_o), 32'd0);
    check("flush_ctrl_m", 32'(ctrl_m), 32'd0);
    check("flush_flags", 32'(flags_o), 32'(mflags));
    @(posedge clk); #1;
    check("flush_after_stall", 32'(stall_o), 32'd0);
    check("flush_after_ctrl", 32'(ctrl_m), 32'd0);

    // stall_i held across a whole MUL
    t = base_instr(); t.op = 3'd5; t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd2; t.fw = 2'b11;
    t.wa = 4'd9;
    drive_d(t);
    @(posedge clk); #1;
    bubble_d(); fwd_a_e = '0; fwd_b_e = '0; stall_i = 1'b1;
    model(t, mflags, eres, ecm, efl, ewd);
    repeat (3) @(posedge clk);
    #1 check("stalli_done_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("stalli_res", aluresult_m, eres);
    check("stalli_ctrl_m", 32'(ctrl_m), 32'(ecm));
    check("stalli_flags", 32'(flags_o), 32'(efl));
    mflags = efl;
    check("stalli_no_restart", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    check("stalli_bubble", 32'(ctrl_m), 32'd0);
    stall_i = 1'b0;

    // reset in the middle of a MUL
    t = base_instr(); t.op = 3'd5; t.rd1 = 32'd12345; t.rd2 = 32'd678; t.fw = 2'b10;
    drive_d(t);
    @(posedge clk); #1;
    bubble_d();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mflags = 4'd0;
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_flags", 32'(flags_o), 32'd0);
    check("midrst_ctrl_m", 32'(ctrl_m), 32'd0);

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      t = rand_instr();
      run_instr(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
